fm_phase_discriminator: RTL
===========================

Name: fm_phase_discriminator

Overview:
- Downstream consumer of the CORDIC angle stream tapped by the AXI snoop stage. Accepts one signed 16-bit phase sample per AXI-Stream beat.
- Computes the wrapped phase difference between consecutive samples, which is the instantaneous frequency (FM demodulation).
- Averages 2^LOG2_DECIM differences and emits one decimated audio sample on an AXI-Stream master with a single-entry output register.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input beat width; phase is in [15:0], upper bits ignored.
- C_M00_AXIS_TDATA_WIDTH, 32, output beat width; sample is in [15:0], upper bits are sign extension.
- LOG2_DECIM, 3, decimation factor exponent (average of 8 differences); legal range 0..8.

Ports:
- s00_axis_aclk, input, 1, sole clock; everything is on its rising edge.
- s00_axis_areset, input, 1, synchronous active-high reset.
- s00_axis_tvalid, input, 1, upstream phase beat valid.
- s00_axis_tready, output, 1, block can accept a phase beat.
- s00_axis_tdata, input, C_S00_AXIS_TDATA_WIDTH, [15:0] signed phase; 0x8000 = -pi, 0x7FFF ≈ +pi.
- m00_axis_tvalid, output, 1, demodulated sample valid.
- m00_axis_tready, input, 1, downstream accepts the sample.
- m00_axis_tdata, output, C_M00_AXIS_TDATA_WIDTH, sign-extended 16-bit averaged frequency sample.
- block_count, output, 16, number of output samples produced since reset; wraps 0xFFFF→0.

Behaviour:
- One clock, synchronous active-high reset. Reset clears:
  - state→PRIME, prev_phase, accumulator, difference counter;
  - m00_axis_tvalid=0, m00_axis_tdata=0, block_count=0.
- Input handshake = s00_axis_tvalid & s00_axis_tready.
  - s00_axis_tready = !m00_axis_tvalid | m00_axis_tready, combinational. It is 1 during reset-released idle.
  - Data is consumed only on a handshake. Gaps in tvalid have no effect.
- State PRIME: the first handshake stores the phase in prev_phase and produces no difference. Next state is ACCUM.
- State ACCUM, on each handshake:
  - d = phase - prev_phase, truncated to 16 bits and treated as signed. This modulo-2^16 wrap is the phase unwrap.
  - prev_phase <= phase.
  - acc <= acc + sign_extend(d); acc is 16+LOG2_DECIM bits signed and cannot overflow.
  - cnt increments.
- On the handshake carrying the 2^LOG2_DECIM-th difference:
  - m00_axis_tdata <= sign_extend((acc + d) >>> LOG2_DECIM), an arithmetic shift that rounds toward -inf.
  - m00_axis_tvalid <= 1, block_count increments.
  - acc and cnt clear to 0.
  - State stays ACCUM; prev_phase carries over, so there is no re-prime between blocks.
- Latency: the output is valid the cycle after the completing input handshake.
- Output handshake = m00_axis_tvalid & m00_axis_tready.
  - On an output handshake with no new completion, tvalid <= 0.
  - While m00_axis_tvalid & !m00_axis_tready: tdata is held stable and s00_axis_tready=0. This is full backpressure; no input is lost.
- Simultaneous output handshake and a completing input handshake: tdata is reloaded with the new sample and tvalid stays 1 (back-to-back throughput).
- LOG2_DECIM=0: every difference is output directly, 1:1 after priming.
- Reset asserted mid-block: the partial accumulation is discarded, any pending output is dropped, and the block returns to PRIME. The next beat re-primes.
- No X on outputs after the first reset cycle.

Test Plan:
- Ramp (LOG2_DECIM=3): phases 0, 0x0100, 0x0200 … 0x0800 (9 beats), m00_tready=1 → exactly one output, tdata=0x00000100, block_count=1, tvalid high for 1 cycle.
- Wrap: ramp of step +0x0200 crossing 0x7F00→0x8100 for 9 beats → output 0x00000200, not a large negative value.
- Negative/rounding: step -100 for 9 beats → 0xFFFFFF9C. Then 8 diffs summing to -1 (seven 0, one -1) → 0xFFFFFFFF (floor).
- Backpressure: hold m00_tready=0 after the first output, keep s00_tvalid=1 → s00_tready=0, tdata held; release → second block completes with no lost beats, block_count=2.
- Continuous streaming: 33 beats at step +0x40 with tvalid/tready random 50% on both sides → 4 outputs, each 0x00000040, in order.
- Reset mid-block: 5 beats, assert reset 1 cycle, then 9 ramp beats of step 0x10 → single output 0x00000010, with no contamination from the pre-reset partial sum.

Source files
------------

// File: rtl/fm_phase_discriminator.sv
// fm_phase_discriminator
//   FM demodulator back end. Takes a stream of signed 16-bit phase samples,
//   forms the wrapped difference between consecutive samples (instantaneous
//   frequency), averages 2^LOG2_DECIM differences and emits one decimated
//   sample through a single-entry AXI-Stream output register.
//
// Ports
//   s00_axis_aclk    : clock, all logic on the rising edge
//   s00_axis_areset  : synchronous active-high reset
//   s00_axis_tvalid  : phase beat valid
//   s00_axis_tready  : phase beat accepted (low only while output is stalled)
//   s00_axis_tdata   : [15:0] signed phase, 0x8000 = -pi; upper bits ignored
//   m00_axis_tvalid  : averaged sample valid
//   m00_axis_tready  : downstream accepts the sample
//   m00_axis_tdata   : sign-extended 16-bit averaged frequency sample
//   block_count      : number of samples produced since reset, wraps at 16 bits

module fm_phase_discriminator #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_DECIM             = 3
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [15:0]                       block_count
);

  // Sum of 2^LOG2_DECIM signed 16-bit differences needs LOG2_DECIM extra bits.
  localparam int ACC_W = 16 + LOG2_DECIM;
  // One extra bit keeps the counter at least 1 bit wide when LOG2_DECIM = 0.
  localparam int CNT_W = LOG2_DECIM + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);

  typedef enum logic {
    PRIME,
    ACCUM
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [15:0]              prev_phase;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;

  logic [15:0]              phase;
  logic signed [15:0]       diff;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [15:0]       avg;
  logic                     in_hs;
  logic                     out_hs;
  logic                     block_done;
  logic                     unused_tdata;

  assign phase = s00_axis_tdata[15:0];

  // Only the low 16 bits carry phase; the rest of the beat is don't-care.
  assign unused_tdata = ^s00_axis_tdata;

  // Modulo-2^16 subtraction is the phase unwrap: a step across +pi/-pi
  // comes out as the short way round.
  assign diff    = phase - prev_phase;
  assign acc_sum = acc + ACC_W'(diff);
  // Arithmetic shift floors toward -inf; the mean of 16-bit values fits 16 bits.
  assign avg     = 16'(acc_sum >>> LOG2_DECIM);

  // The output register is single-entry, so input stalls only while it is
  // full and not draining.
  assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
  assign in_hs           = s00_axis_tvalid && s00_axis_tready;
  assign out_hs          = m00_axis_tvalid && m00_axis_tready;
  assign block_done      = in_hs && (state == ACCUM) && (cnt == CNT_LAST);

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers update from the same pre-edge values regardless of order.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) state <= PRIME;
    else                 state <= state_next;
  end

  // NOTE: default assigned first so no path through this block leaves
  // state_next unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    if (state == PRIME && in_hs) state_next = ACCUM;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      prev_phase      <= '0;
      acc             <= '0;
      cnt             <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      block_count     <= '0;
    end else begin
      if (in_hs) begin
        prev_phase <= phase;
        if (state == ACCUM) begin
          if (block_done) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
          end
        end
      end

      // A completion wins over a drain so back-to-back blocks keep tvalid high.
      if (block_done) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(avg);
        block_count     <= block_count + 16'd1;
      end else if (out_hs) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
